// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_READ  = c_ST_READ,
        ST_WRITE = c_ST_WRITE,
        ST_RESP  = c_ST_RESP
    } lsu_state_t;

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LD  = 3'b011;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;
    localparam logic [2:0] c_LWU = 3'b110;

    localparam logic [2:0] c_SB  = 3'b000;
    localparam logic [2:0] c_SH  = 3'b001;
    localparam logic [2:0] c_SW  = 3'b010;
    localparam logic [2:0] c_SD  = 3'b011;

    // funct3[1:0] encodes log2 of the access size for both loads and stores
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = |off[1:0];
            default: is_misaligned = |off;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Load extract/extend and store byte-merge datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [2:0]  i_offset,
    input  logic [63:0] i_read_data,
    input  logic [63:0] i_store_data,
    output logic [63:0] o_load_result,
    output logic [63:0] o_merge_result
);

    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [63:0] w_mask;
    logic [63:0] w_lane_mask;

    assign w_shamt   = {i_offset, 3'b000};
    assign w_shifted = i_read_data >> w_shamt;

    always_comb begin
        o_load_result = w_shifted;
        case (i_funct3)
            c_LB:    o_load_result = {{56{w_shifted[7]}},  w_shifted[7:0]};
            c_LH:    o_load_result = {{48{w_shifted[15]}}, w_shifted[15:0]};
            c_LW:    o_load_result = {{32{w_shifted[31]}}, w_shifted[31:0]};
            c_LBU:   o_load_result = {56'd0, w_shifted[7:0]};
            c_LHU:   o_load_result = {48'd0, w_shifted[15:0]};
            c_LWU:   o_load_result = {32'd0, w_shifted[31:0]};
            default: o_load_result = w_shifted;
        endcase
    end

    always_comb begin
        w_mask = '1;
        case (i_funct3[1:0])
            2'b00:   w_mask = 64'h0000_0000_0000_00FF;
            2'b01:   w_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign w_lane_mask    = w_mask << w_shamt;
    assign o_merge_result = (i_read_data & ~w_lane_mask) | ((i_store_data & w_mask) << w_shamt);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage FSM driving a 64-bit aligned data memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        resp_valid,
    output logic [63:0] load_data,
    output logic        fault,
    output logic [63:0] address,
    output logic [63:0] write_data,
    output logic        memoryread,
    output logic        memorywrite,
    input  logic [63:0] read_data
);

    lsu_state_t  r_state;
    logic [2:0]  r_funct3;
    logic [2:0]  r_offset;
    logic [63:0] r_addr;
    logic [63:0] r_buf;
    logic [63:0] r_load_data;
    logic        r_is_load;
    logic        r_fault;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_fault;
    logic [63:0] w_load_result;
    logic [63:0] w_merge_result;

    assign w_is_load  = req_load & ~req_store;
    assign w_is_store = req_store & ~req_load;
    assign w_fault    = (req_load == req_store)
                     || (addr >= 64'(MEM_BYTES))
                     || (w_is_store && funct3[2])
                     || (w_is_load && funct3 == 3'b111)
                     || is_misaligned(funct3, addr[2:0]);

    lsu_align u_align (
        .i_funct3       (r_funct3),
        .i_offset       (r_offset),
        .i_read_data    (read_data),
        .i_store_data   (r_buf),
        .o_load_result  (w_load_result),
        .o_merge_result (w_merge_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_funct3    <= '0;
            r_offset    <= '0;
            r_addr      <= '0;
            r_buf       <= '0;
            r_load_data <= '0;
            r_is_load   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= funct3;
                        r_offset  <= addr[2:0];
                        r_addr    <= {addr[63:3], 3'b000};
                        r_buf     <= store_data;
                        r_is_load <= w_is_load;
                        r_fault   <= w_fault;
                        if (w_fault) begin
                            r_load_data <= '0;
                            r_state     <= ST_RESP;
                        end else if (w_is_load || funct3[1:0] != 2'b11) begin
                            r_state <= ST_READ;
                        end else begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                // sub-doubleword stores read the word first so the merge keeps neighbours
                ST_READ: begin
                    if (r_is_load) begin
                        r_load_data <= w_load_result;
                        r_state     <= ST_RESP;
                    end else begin
                        r_buf   <= w_merge_result;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_load_data <= '0;
                    r_state     <= ST_RESP;
                end
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE) & ~reset;
    assign resp_valid  = (r_state == ST_RESP);
    assign fault       = r_fault;
    assign memoryread  = (r_state == ST_READ);
    assign memorywrite = (r_state == ST_WRITE) & ~reset;
    assign address     = r_addr;
    assign write_data  = r_buf;
    assign load_data   = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench with a byte-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  funct3;
    logic [63:0] addr, store_data;
    logic        resp_valid, fault, memoryread, memorywrite;
    logic [63:0] load_data, address, write_data, read_data;

    logic [7:0]  mem [0:63];
    int          errors = 0;
    int          checks = 0;
    int          bad_strobe = 0;

    int          lat, n_rd, n_wr;
    logic [63:0] rd_addr, wr_addr, wr_data, got_data;
    logic        got_fault;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data),
        .fault(fault), .address(address), .write_data(write_data),
        .memoryread(memoryread), .memorywrite(memorywrite), .read_data(read_data)
    );

    always_comb begin
        read_data = '0;
        if (address < 64)
            for (int b = 0; b < 8; b++) read_data[8*b +: 8] = mem[int'(address[5:0]) + b];
    end

    always @(posedge clk) begin
        if (memorywrite && address < 64)
            for (int b = 0; b < 8; b++) mem[int'(address[5:0]) + b] <= write_data[8*b +: 8];
    end

    // strobes must be exclusive and absent whenever the unit is idle or responding
    always @(negedge clk) begin
        if ((memoryread && memorywrite) ||
            ((memoryread || memorywrite) && (resp_valid || req_ready)))
            bad_strobe++;
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd);
        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_store = st; funct3 = f3; addr = a; store_data = sd;
        lat = 0; n_rd = 0; n_wr = 0; rd_addr = 'x; wr_addr = 'x; wr_data = 'x;
        got_data = 'x; got_fault = 1'bx;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (memoryread)  begin n_rd++; rd_addr = address; end
            if (memorywrite) begin n_wr++; wr_addr = address; wr_data = write_data; end
            if (resp_valid) begin
                lat = k; got_data = load_data; got_fault = fault;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++; if ({resp_valid, fault, memoryread, memorywrite} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: got %b expected 0000", {resp_valid, fault, memoryread, memorywrite}); end
        checks++; if ({load_data, address, write_data} !== 192'd0) begin errors++;
            $display("FAIL reset_data: got %h %h %h expected zeros", load_data, address, write_data); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_ld;
        issue(1, 0, 3'b011, 64'd16, 64'd0);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld_latency: got %0d expected 2", lat); end
        checks++; if (n_rd !== 1 || rd_addr !== 64'd16 || n_wr !== 0) begin errors++;
            $display("FAIL ld_strobes: got rd=%0d@%h wr=%0d expected rd=1@10 wr=0", n_rd, rd_addr, n_wr); end
        checks++; if (got_data !== 64'd3 || got_fault !== 1'b0) begin errors++;
            $display("FAIL ld_data: got %h fault=%b expected 3 fault=0", got_data, got_fault); end
    endtask

    task automatic test_sub_store;
        issue(0, 1, 3'b000, 64'd9, 64'h0000_0000_0000_00FF);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        checks++; if (n_rd !== 1 || rd_addr !== 64'd8 || n_wr !== 1 || wr_addr !== 64'd8) begin errors++;
            $display("FAIL sb_strobes: got rd=%0d@%h wr=%0d@%h expected 1@8 1@8", n_rd, rd_addr, n_wr, wr_addr); end
        checks++; if (wr_data !== 64'h0000_0000_0000_FF02) begin errors++;
            $display("FAIL sb_write_data: got %h expected 000000000000ff02", wr_data); end
        checks++; if (got_data !== 64'd0 || got_fault !== 1'b0) begin errors++;
            $display("FAIL sb_resp: got %h fault=%b expected 0 fault=0", got_data, got_fault); end
        issue(1, 0, 3'b000, 64'd9, 64'd0);
        checks++; if (got_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++;
            $display("FAIL lb_sign: got %h expected ffffffffffffffff", got_data); end
        issue(1, 0, 3'b100, 64'd9, 64'd0);
        checks++; if (got_data !== 64'h0000_0000_0000_00FF) begin errors++;
            $display("FAIL lbu_zero: got %h expected ff", got_data); end
    endtask

    task automatic test_sd;
        issue(0, 1, 3'b011, 64'd24, 64'h8877_6655_4433_2211);
        checks++; if (lat !== 2 || n_rd !== 0 || n_wr !== 1 || wr_addr !== 64'd24) begin errors++;
            $display("FAIL sd_timing: got lat=%0d rd=%0d wr=%0d@%h expected 2 0 1@18", lat, n_rd, n_wr, wr_addr); end
        checks++; if (wr_data !== 64'h8877_6655_4433_2211) begin errors++;
            $display("FAIL sd_write_data: got %h expected 8877665544332211", wr_data); end
        issue(1, 0, 3'b010, 64'd28, 64'd0);
        checks++; if (got_data !== 64'hFFFF_FFFF_8877_6655) begin errors++;
            $display("FAIL lw_sign: got %h expected ffffffff88776655", got_data); end
        issue(1, 0, 3'b110, 64'd28, 64'd0);
        checks++; if (got_data !== 64'h0000_0000_8877_6655) begin errors++;
            $display("FAIL lwu_zero: got %h expected 88776655", got_data); end
        issue(1, 0, 3'b001, 64'd26, 64'd0);
        checks++; if (got_data !== 64'h0000_0000_0000_4433) begin errors++;
            $display("FAIL lh_pos: got %h expected 4433", got_data); end
        issue(1, 0, 3'b101, 64'd30, 64'd0);
        checks++; if (got_data !== 64'h0000_0000_0000_8877) begin errors++;
            $display("FAIL lhu_zero: got %h expected 8877", got_data); end
    endtask

    task automatic test_faults;
        logic [3:0]  ld_v [6];
        logic [2:0]  f3_v [6];
        logic [63:0] a_v  [6];
        ld_v = '{4'b10, 4'b01, 4'b11, 4'b00, 4'b01, 4'b10};
        f3_v = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b100, 3'b111};
        a_v  = '{64'd6, 64'd64, 64'd0, 64'd0, 64'd0, 64'd0};
        for (int i = 0; i < 6; i++) begin
            issue(ld_v[i][1], ld_v[i][0], f3_v[i], a_v[i], 64'h1234);
            checks++; if (lat !== 1 || got_fault !== 1'b1 || n_rd !== 0 || n_wr !== 0 || got_data !== 64'd0) begin
                errors++;
                $display("FAIL fault_%0d: got lat=%0d fault=%b rd=%0d wr=%0d data=%h expected 1 1 0 0 0",
                         i, lat, got_fault, n_rd, n_wr, got_data);
            end
        end
    endtask

    task automatic test_reset_mid;
        int seen_resp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; funct3 = 3'b001; addr = 64'd40; store_data = 64'hBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (memorywrite !== 1'b0 || address !== 64'd40) begin errors++;
            $display("FAIL rst_write_gate: got wr=%b addr=%h expected 0 28", memorywrite, address); end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) seen_resp++;
        end
        checks++; if (seen_resp !== 0) begin errors++; $display("FAIL rst_mid_resp: got %0d expected 0", seen_resp); end
        issue(1, 0, 3'b011, 64'd40, 64'd0);
        checks++; if (got_data !== 64'd6) begin errors++; $display("FAIL rst_mid_mem: got %h expected 6", got_data); end
    endtask

    task automatic test_back_to_back;
        logic [9:0]  rdy_seen;
        int          acc = 0;
        int          nresp = 0;
        int          resp_cyc [3];
        logic [63:0] resp_dat [3];
        logic [2:0]  resp_flt;
        logic [63:0] exp_dat [3];
        exp_dat = '{64'd1, 64'd0, 64'h0000_0000_00A5_0007};
        resp_flt = '0;
        rdy_seen = '0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k < 10 && acc < 3) begin
                req_valid = 1'b1;
                case (acc)
                    0: begin req_load = 1; req_store = 0; funct3 = 3'b011; addr = 64'd0;  store_data = 64'd0; end
                    1: begin req_load = 0; req_store = 1; funct3 = 3'b000; addr = 64'd50; store_data = 64'hA5; end
                    default: begin req_load = 1; req_store = 0; funct3 = 3'b011; addr = 64'd48; store_data = 64'd0; end
                endcase
            end else begin
                req_valid = 1'b0;
            end
            if (k < 10) rdy_seen[k] = req_ready;
            if (resp_valid) begin
                if (nresp < 3) begin
                    resp_cyc[nresp] = k; resp_dat[nresp] = load_data; resp_flt[nresp] = fault;
                end
                nresp++;
            end
            if (req_valid && req_ready) acc++;
        end
        req_valid = 1'b0;
        checks++; if (rdy_seen !== 10'b0010001001) begin errors++;
            $display("FAIL b2b_ready: got %b expected 0010001001", rdy_seen); end
        checks++; if (nresp !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", nresp); end
        if (nresp == 3) begin
            checks++; if (resp_cyc[0] !== 2 || resp_cyc[1] !== 6 || resp_cyc[2] !== 9) begin errors++;
                $display("FAIL b2b_cycles: got %0d %0d %0d expected 2 6 9", resp_cyc[0], resp_cyc[1], resp_cyc[2]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (resp_dat[i] !== exp_dat[i] || resp_flt[i] !== 1'b0) begin errors++;
                    $display("FAIL b2b_resp_%0d: got %h fault=%b expected %h fault=0", i, resp_dat[i], resp_flt[i], exp_dat[i]); end
            end
        end
        checks++; if (bad_strobe !== 0) begin errors++;
            $display("FAIL strobe_exclusive: got %0d bad cycles expected 0", bad_strobe); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (i % 8 == 0) ? 8'(i / 8 + 1) : 8'd0;
        reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        funct3 = 3'b000; addr = '0; store_data = '0;
        test_reset();
        test_ld();
        test_sub_store();
        test_sd();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
